ps2_key_tracker: RTL and testbench

- Sits between the PS/2 interface (`ps2_key_pressed` / `ps2_key_data`) and the processor I/O path.
- Decodes Set-2 make, break and E0-extended scan-code sequences into a held-key bitmap for the Pong controls and derives per-paddle direction.
- Buffers de-duplicated key press/release events in a small FIFO that the processor pops through a memory-mapped read.

---
 rtl/ps2_key_pkg.sv | 80 ++++++++
 rtl/ps2_evt_fifo.sv | 73 +++++++
 rtl/ps2_key_tracker.sv | 160 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared scan-code constants, key indices, decoder states and helpers for the
// PS/2 key tracker.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_S     = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } ps2_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_match_t;

  typedef struct packed {
    logic       is_break;
    logic [2:0] idx;
  } key_evt_t;

  // Up/Down only exist behind the E0 prefix; every other key only without it.
  function automatic key_match_t key_lookup(input logic [7:0] code, input logic ext);
    key_match_t m;
    m = '0;
    if (ext) begin
      case (code)
        SC_UP:   m = '{hit: 1'b1, idx: KEY_UP};
        SC_DOWN: m = '{hit: 1'b1, idx: KEY_DOWN};
        default: m = '0;
      endcase
    end else begin
      case (code)
        SC_W:     m = '{hit: 1'b1, idx: KEY_W};
        SC_S:     m = '{hit: 1'b1, idx: KEY_S};
        SC_SPACE: m = '{hit: 1'b1, idx: KEY_SPACE};
        SC_ENTER: m = '{hit: 1'b1, idx: KEY_ENTER};
        SC_ESC:   m = '{hit: 1'b1, idx: KEY_ESC};
        SC_P:     m = '{hit: 1'b1, idx: KEY_P};
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

  function automatic logic [1:0] paddle_dir(input logic up, input logic down);
    if (up && !down) begin
      return DIR_UP;
    end else if (down && !up) begin
      return DIR_DOWN;
    end
    return DIR_IDLE;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag; a push into a
// full FIFO is only dropped when no pop frees a slot in the same cycle.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;

  logic empty, full, do_pop, do_push, drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A drop in the same cycle as a clear must leave the flag set.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid    = !empty;
  assign rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code decoder: tracks held Pong keys, derives paddle directions and
// queues de-duplicated press/release events for the processor.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_key_pressed,
  input  logic [7:0]  ps2_key_data,
  input  logic        evt_rd,
  input  logic        ovf_clr,
  output logic [7:0]  key_state,
  output logic [1:0]  paddle_left_dir,
  output logic [1:0]  paddle_right_dir,
  output logic        evt_valid,
  output logic [3:0]  evt_data,
  output logic        evt_overflow,
  output logic [31:0] status_word
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e  state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic        pressed_q, pressed_d;
  logic [7:0]  key_q, key_d;
  logic [1:0]  left_q, left_d;
  logic [1:0]  right_q, right_d;

  logic        accept;
  key_match_t  m_norm, m_ext;
  logic        mk, bk;
  logic [2:0]  kidx;
  logic        push;
  key_evt_t    evt;

  assign pressed_d = ps2_key_pressed;
  assign accept    = ps2_key_pressed && !pressed_q;
  assign m_norm    = key_lookup(ps2_key_data, 1'b0);
  assign m_ext     = key_lookup(ps2_key_data, 1'b1);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    key_d   = key_q;
    mk      = 1'b0;
    bk      = 1'b0;
    kidx    = '0;
    push    = 1'b0;
    evt     = '0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == SC_BRK) begin
            state_d = ST_BRK;
          end else if (ps2_key_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_key_data == SC_BAT) begin
            key_d = '0;
          end else if (m_norm.hit) begin
            mk   = 1'b1;
            kidx = m_norm.idx;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (m_norm.hit) begin
            bk   = 1'b1;
            kidx = m_norm.idx;
          end
        end
        ST_EXT: begin
          if (ps2_key_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            if (m_ext.hit) begin
              mk   = 1'b1;
              kidx = m_ext.idx;
            end
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (m_ext.hit) begin
            bk   = 1'b1;
            kidx = m_ext.idx;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Abandon a dangling prefix so a lost byte cannot corrupt the next key.
      if (cnt_q == T_LAST) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Typematic repeats and breaks of keys not held produce no event.
    if (mk && !key_q[kidx]) begin
      key_d[kidx] = 1'b1;
      push        = 1'b1;
      evt         = '{is_break: 1'b0, idx: kidx};
    end
    if (bk && key_q[kidx]) begin
      key_d[kidx] = 1'b0;
      push        = 1'b1;
      evt         = '{is_break: 1'b1, idx: kidx};
    end
  end

  assign left_d  = paddle_dir(key_d[KEY_W], key_d[KEY_S]);
  assign right_d = paddle_dir(key_d[KEY_UP], key_d[KEY_DOWN]);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      key_q     <= '0;
      left_q    <= DIR_IDLE;
      right_q   <= DIR_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      key_q     <= key_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (resetn),
    .push     (push),
    .wdata    (evt),
    .pop      (evt_rd),
    .ovf_clr  (ovf_clr),
    .rdata    (evt_data),
    .valid    (evt_valid),
    .overflow (evt_overflow)
  );

  assign key_state        = key_q;
  assign paddle_left_dir  = left_q;
  assign paddle_right_dir = right_q;
  assign status_word      = {evt_overflow, evt_valid, 18'b0, evt_data, key_q};

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed table-driven bench for ps2_key_tracker (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_key_tracker;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        ps2_key_pressed = 1'b0;
  logic [7:0]  ps2_key_data = '0;
  logic        evt_rd = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [7:0]  key_state;
  logic [1:0]  paddle_left_dir;
  logic [1:0]  paddle_right_dir;
  logic        evt_valid;
  logic [3:0]  evt_data;
  logic        evt_overflow;
  logic [31:0] status_word;

  ps2_key_tracker #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .ps2_key_pressed  (ps2_key_pressed),
    .ps2_key_data     (ps2_key_data),
    .evt_rd           (evt_rd),
    .ovf_clr          (ovf_clr),
    .key_state        (key_state),
    .paddle_left_dir  (paddle_left_dir),
    .paddle_right_dir (paddle_right_dir),
    .evt_valid        (evt_valid),
    .evt_data         (evt_data),
    .evt_overflow     (evt_overflow),
    .status_word      (status_word)
  );

  always #5 clock = ~clock;

  localparam int OP_BYTE     = 0;
  localparam int OP_RD       = 1;
  localparam int OP_CLR      = 2;
  localparam int OP_NOP      = 3;
  localparam int OP_BYTE_RD  = 4;
  localparam int OP_BYTE_CLR = 5;
  localparam int OP_RST      = 6;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic [7:0] ek;
    logic [1:0] el;
    logic [1:0] er;
    logic       ev;
    logic [3:0] ed;
    logic       eo;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic add(input int op, input logic [7:0] data, input logic [7:0] ek,
                     input logic [1:0] el, input logic [1:0] er, input logic ev,
                     input logic [3:0] ed, input logic eo);
    vec_t v;
    v.op = op; v.data = data; v.ek = ek; v.el = el; v.er = er;
    v.ev = ev; v.ed = ed; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] ek, input logic [1:0] el,
                       input logic [1:0] er, input logic ev, input logic [3:0] ed,
                       input logic eo);
    logic [17:0] act, exp;
    logic [31:0] sexp;
    act  = {key_state, paddle_left_dir, paddle_right_dir, evt_valid, evt_data, evt_overflow};
    exp  = {ek, el, er, ev, ed, eo};
    sexp = {eo, ev, 18'b0, ed, ek};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s outputs {key,l,r,v,d,o}: got %h required %h", name, act, exp);
    n_total++;
    if (status_word === sexp) n_pass++;
    else $display("FAIL %s status_word: got %h required %h", name, status_word, sexp);
  endtask

  // Each step: drive for one edge, release for one edge, sample on the negedge.
  task automatic do_step(input int op, input logic [7:0] data);
    @(negedge clock);
    case (op)
      OP_BYTE:     begin ps2_key_pressed = 1'b1; ps2_key_data = data; end
      OP_RD:       evt_rd = 1'b1;
      OP_CLR:      ovf_clr = 1'b1;
      OP_BYTE_RD:  begin ps2_key_pressed = 1'b1; ps2_key_data = data; evt_rd = 1'b1; end
      OP_BYTE_CLR: begin ps2_key_pressed = 1'b1; ps2_key_data = data; ovf_clr = 1'b1; end
      OP_RST:      resetn = 1'b0;
      default:     ;
    endcase
    if (op == OP_NOP) begin
      repeat (int'(data)) @(negedge clock);
    end else begin
      @(negedge clock);
      ps2_key_pressed = 1'b0;
      evt_rd          = 1'b0;
      ovf_clr         = 1'b0;
      resetn          = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    // make / repeat / break of W, then drain
    add(OP_BYTE, 8'h1D, 8'h01, 2'b01, 2'b00, 1, 4'h0, 0);
    add(OP_BYTE, 8'h1D, 8'h01, 2'b01, 2'b00, 1, 4'h0, 0);
    add(OP_BYTE, 8'hF0, 8'h01, 2'b01, 2'b00, 1, 4'h0, 0);
    add(OP_BYTE, 8'h1D, 8'h00, 2'b00, 2'b00, 1, 4'h0, 0);
    add(OP_RD,   8'h00, 8'h00, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_RD,   8'h00, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_RD,   8'h00, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    // extended Up, plain 75 ignored, W+S, Down, then fill past depth
    add(OP_BYTE, 8'hE0, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'h75, 8'h04, 2'b00, 2'b01, 1, 4'h2, 0);
    add(OP_BYTE, 8'h75, 8'h04, 2'b00, 2'b01, 1, 4'h2, 0);
    add(OP_BYTE, 8'h1D, 8'h05, 2'b01, 2'b01, 1, 4'h2, 0);
    add(OP_BYTE, 8'h1B, 8'h07, 2'b00, 2'b01, 1, 4'h2, 0);
    add(OP_BYTE, 8'hE0, 8'h07, 2'b00, 2'b01, 1, 4'h2, 0);
    add(OP_BYTE, 8'h72, 8'h0F, 2'b00, 2'b00, 1, 4'h2, 0);
    add(OP_BYTE, 8'h29, 8'h1F, 2'b00, 2'b00, 1, 4'h2, 1);
    add(OP_CLR,  8'h00, 8'h1F, 2'b00, 2'b00, 1, 4'h2, 0);
    add(OP_BYTE_RD, 8'h5A, 8'h3F, 2'b00, 2'b00, 1, 4'h0, 0);
    add(OP_RD,   8'h00, 8'h3F, 2'b00, 2'b00, 1, 4'h1, 0);
    add(OP_RD,   8'h00, 8'h3F, 2'b00, 2'b00, 1, 4'h3, 0);
    add(OP_RD,   8'h00, 8'h3F, 2'b00, 2'b00, 1, 4'h5, 0);
    add(OP_RD,   8'h00, 8'h3F, 2'b00, 2'b00, 0, 4'h0, 0);
    // breaks refill the FIFO; overflow set and clear together -> set wins
    add(OP_BYTE, 8'hF0, 8'h3F, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'h1D, 8'h3E, 2'b10, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'hF0, 8'h3E, 2'b10, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'h1B, 8'h3C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'hF0, 8'h3C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'h29, 8'h2C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'hF0, 8'h2C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'h5A, 8'h0C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'hE0, 8'h0C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE, 8'hF0, 8'h0C, 2'b00, 2'b00, 1, 4'h8, 0);
    add(OP_BYTE_CLR, 8'h75, 8'h08, 2'b00, 2'b10, 1, 4'h8, 1);
    add(OP_CLR,  8'h00, 8'h08, 2'b00, 2'b10, 1, 4'h8, 0);
    // prefix timeout, then a prefix that is completed before the timeout
    add(OP_RST,  8'h00, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'hE0, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_NOP,  8'd20, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'h75, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'hE0, 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_NOP,  8'd8,  8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    add(OP_BYTE, 8'h75, 8'h04, 2'b00, 2'b01, 1, 4'h2, 0);

    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("reset", 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_step(vecs[i].op, vecs[i].data);
      check($sformatf("vec%0d", i), vecs[i].ek, vecs[i].el, vecs[i].er,
            vecs[i].ev, vecs[i].ed, vecs[i].eo);
    end

    // strobe held high for three cycles counts as one byte
    @(negedge clock);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = 8'h29;
    repeat (3) @(negedge clock);
    ps2_key_pressed = 1'b0;
    @(negedge clock);
    check("hold_29", 8'h14, 2'b00, 2'b01, 1, 4'h2, 0);
    do_step(OP_BYTE, 8'hAA);
    check("bat_clear", 8'h00, 2'b00, 2'b00, 1, 4'h2, 0);
    do_step(OP_RD, 8'h00);
    check("hold_evt", 8'h00, 2'b00, 2'b00, 1, 4'h4, 0);
    do_step(OP_RD, 8'h00);
    check("hold_single", 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);

    // reset after a break prefix discards it
    do_step(OP_BYTE, 8'h1D);
    do_step(OP_BYTE, 8'hF0);
    do_step(OP_RST, 8'h00);
    check("rst_mid", 8'h00, 2'b00, 2'b00, 0, 4'h0, 0);
    do_step(OP_BYTE, 8'h1D);
    check("rst_then_make", 8'h01, 2'b01, 2'b00, 1, 4'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
